pcie_s7_irq_ctrl: RTL and testbench
===================================

# pcie_s7_irq_ctrl

Parametrised interrupt controller for the `pcie_s7` endpoint.
- Collects up to `N_CHANNELS` edge-triggered interrupt sources into a pending/mask register set.
- Serialises them onto the core's `cfg_interrupt*` handshake as MSI messages or legacy INTx assert/deassert, selected at runtime by `cfg_interrupt_msienable`.
- Sits between user logic and the `pcie_s7` cfg interrupt ports, clocked from `user_clk_out`.

## Interface
Parameters:
- `N_CHANNELS`, 8: number of interrupt sources, 1..32.
- `COUNT_W`, 16: width of the completed-handshake counter.

Ports:
- `sys_clk`  in  1  block clock; connect to `user_clk_out`.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `user_lnk_up`  in  1  link up from core.
- `irq_req`  in  N_CHANNELS  source requests; each rising edge is one interrupt event.
- `irq_mask`  in  N_CHANNELS  1 = channel enabled.
- `irq_clear`  in  N_CHANNELS  one-cycle pulse; clears pending bit (W1C from software).
- `irq_pending`  out  N_CHANNELS  pending register.
- `cfg_interrupt`  out  1  request to core.
- `cfg_interrupt_assert`  out  1  INTx level: 1 = assert, 0 = deassert. Forced to 0 in MSI mode.
- `cfg_interrupt_di`  out  8  MSI vector; 0 in legacy mode.
- `cfg_interrupt_rdy`  in  1  core acknowledge.
- `cfg_interrupt_msienable`  in  1  1 = MSI mode, 0 = legacy.
- `cfg_interrupt_mmenable`  in  3  log2 of allocated MSI vectors.
- `irq_count`  out  COUNT_W  completed handshakes.

## Operation
- **Reset values:** all outputs 0; `irq_req` history register 0; `sent` 0; `intx_on` 0; RR pointer 0; FSM in IDLE.
- **Edge detect:** `rise = irq_req & ~irq_req_q`.
  - `pending[i]` is set on `rise[i]` and cleared by `irq_clear[i]`.
  - Simultaneous set and clear: set wins.
- **`sent[i]`** means an MSI has been issued for the current pending event.
  - Cleared when `pending[i]` clears.
  - Cleared on `rise[i]` while already pending, so a re-trigger produces another MSI.
- **FSM states:** IDLE, MSI_REQ, INTX_REQ.
- **IDLE, no new request:** no request starts while `user_lnk_up` = 0.
- **IDLE, MSI mode:** if `cand = pending & irq_mask & ~sent` is nonzero, grant channel `g`.
  - `g` is the first set bit of `cand` at or after the RR pointer, wrapping at `N_CHANNELS-1`.
  - Go to MSI_REQ with `cfg_interrupt_di = g & ((1 << min(mmenable,5)) - 1)`. With `mmenable` = 0, every vector is 0.
- **IDLE, MSI mode with `intx_on` = 1:** issue an INTx deassert first (INTX_REQ, assert = 0) before any MSI.
- **IDLE, legacy mode:** `level = |(pending & irq_mask)`.
  - `level & ~intx_on` -> INTX_REQ with assert = 1.
  - `~level & intx_on` -> INTX_REQ with assert = 0.
- **MSI_REQ / INTX_REQ:**
  - Hold `cfg_interrupt` = 1 with `di` and `assert` stable until `cfg_interrupt_rdy` is sampled 1.
  - Then drop `cfg_interrupt` and increment `irq_count` (wraps).
  - MSI: set `sent[g]`; RR pointer = `g+1` mod `N_CHANNELS`.
  - INTx: `intx_on` = issued assert value.
  - Return to IDLE.
- **Mode or link changes mid-request:** an in-flight request is never abandoned. Mode is latched at request start; changes of `msienable`, `mmenable` or `user_lnk_up` during the request are ignored until it completes.
- **Link down:** `intx_on` is cleared after any in-flight request completes (the core drops INTx state on link down). Pending bits are retained.
- **Masking:** masking a channel does not clear pending; unmasking a pending, unsent channel fires it.

## Timing
- `irq_req` first sampled 1 at edge k -> `irq_pending` = 1 after edge k -> `cfg_interrupt` = 1 after edge k+1. Latency is 2 cycles.
- `cfg_interrupt_rdy` sampled 1 at edge m -> `cfg_interrupt` = 0 and `irq_count` updated after edge m.
  - The next request can assert at the earliest after edge m+1.
  - `cfg_interrupt` is low for at least 1 cycle between requests.
- `rdy` asserted while `cfg_interrupt` = 0 is ignored.
- Reset asserted mid-request: all state is cleared immediately (asynchronous); `cfg_interrupt` = 0 with no completion counted.
- Throughput: one handshake per 2 + (rdy wait) cycles.

## Test plan
- **MSI single:** msienable=1, mmenable=3, pulse `irq_req[5]` -> `cfg_interrupt` high 2 cycles later with di=5. rdy held low 4 cycles, then high 1 cycle -> `cfg_interrupt` drops, `irq_count`=1, `irq_pending`=0x20.
- **Round robin / vector fold:** msienable=1, mmenable=1, `irq_req` 0xFF rising together -> 8 MSIs in channel order 0..7 with di = 0,1,0,1,0,1,0,1. `irq_count`=8. No repeat until `irq_clear` or re-trigger.
- **Legacy:** msienable=0, `irq_req[2]` rise -> INTX_REQ assert=1, di=0. `irq_clear[2]` pulse -> INTX_REQ assert=0. `irq_count`=2.
- **Boundaries:**
  - `irq_clear` and rise on the same channel in the same cycle -> pending stays 1.
  - Masked pending channel -> no request.
  - Unmask -> MSI fires 1 cycle later.
- **Mode switch:** legacy with INTx asserted, switch msienable to 1 -> INTx deassert handshake first, then MSI for each pending channel.
- **Link / reset:**
  - `user_lnk_up` low -> no new request.
  - Link drop during an outstanding request -> request held until rdy.
  - `sys_rst_n` low mid-request -> all outputs 0 immediately; after release, no request until a new edge.

Source files
------------

// File: rtl/pcie_s7_irq_ctrl.sv
// Edge-triggered interrupt collector for the pcie_s7 endpoint; serialises pending
// channels onto the cfg_interrupt handshake as MSI vectors or INTx assert/deassert.
module pcie_s7_irq_ctrl #(
    parameter int unsigned N_CHANNELS = 8,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  user_lnk_up,
    input  logic [N_CHANNELS-1:0] irq_req,
    input  logic [N_CHANNELS-1:0] irq_mask,
    input  logic [N_CHANNELS-1:0] irq_clear,
    output logic [N_CHANNELS-1:0] irq_pending,
    output logic                  cfg_interrupt,
    output logic                  cfg_interrupt_assert,
    output logic [7:0]            cfg_interrupt_di,
    input  logic                  cfg_interrupt_rdy,
    input  logic                  cfg_interrupt_msienable,
    input  logic [2:0]            cfg_interrupt_mmenable,
    output logic [COUNT_W-1:0]    irq_count
);

    localparam int unsigned PTR_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [PTR_W:0] N_P = (PTR_W + 1)'(N_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        MSI_REQ,
        INTX_REQ
    } state_t;

    state_t                state;
    logic [N_CHANNELS-1:0] irq_req_q;
    logic [N_CHANNELS-1:0] sent;
    logic                  intx_on;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_q;

    logic [N_CHANNELS-1:0] rise;
    logic [N_CHANNELS-1:0] pending_nxt;
    logic [N_CHANNELS-1:0] sent_set;
    logic [N_CHANNELS-1:0] sent_clr;
    logic [N_CHANNELS-1:0] sent_nxt;
    logic [N_CHANNELS-1:0] cand;
    logic [N_CHANNELS-1:0] rot;
    logic [PTR_W-1:0]      off;
    logic [PTR_W:0]        g_sum;
    logic [PTR_W-1:0]      grant;
    logic                  grant_vld;
    logic [PTR_W:0]        rr_inc;
    logic [PTR_W-1:0]      rr_nxt;
    logic                  level;
    logic [2:0]            mm_eff;
    logic [7:0]            vec_mask;
    logic [7:0]            msi_vec;
    logic                  done;

    assign rise        = irq_req & ~irq_req_q;
    // set wins over a same-cycle clear
    assign pending_nxt = (irq_pending & ~irq_clear) | rise;
    assign done        = (state != IDLE) && cfg_interrupt_rdy;

    assign sent_set = (state == MSI_REQ && cfg_interrupt_rdy) ? (N_CHANNELS'(1) << grant_q) : '0;
    // a re-trigger on a still-pending channel re-arms it for another MSI
    assign sent_clr = ~pending_nxt | (rise & irq_pending);
    assign sent_nxt = (sent | sent_set) & ~sent_clr;

    assign cand  = irq_pending & irq_mask & ~sent;
    assign level = |(irq_pending & irq_mask);

    // rotate so the RR pointer sits at bit 0, then take the lowest set bit
    assign rot = N_CHANNELS'({cand, cand} >> rr_ptr);

    always_comb begin
        off       = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            if (!grant_vld && rot[i]) begin
                grant_vld = 1'b1;
                off       = PTR_W'(i);
            end
        end
    end

    assign g_sum  = {1'b0, rr_ptr} + {1'b0, off};
    assign grant  = (g_sum >= N_P) ? PTR_W'(g_sum - N_P) : g_sum[PTR_W-1:0];

    assign rr_inc = {1'b0, grant_q} + (PTR_W + 1)'(1);
    assign rr_nxt = (rr_inc >= N_P) ? '0 : rr_inc[PTR_W-1:0];

    assign mm_eff   = (cfg_interrupt_mmenable > 3'd5) ? 3'd5 : cfg_interrupt_mmenable;
    assign vec_mask = (8'd1 << mm_eff) - 8'd1;
    assign msi_vec  = 8'(grant) & vec_mask;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                <= IDLE;
            irq_req_q            <= '0;
            irq_pending          <= '0;
            sent                 <= '0;
            intx_on              <= 1'b0;
            rr_ptr               <= '0;
            grant_q              <= '0;
            cfg_interrupt        <= 1'b0;
            cfg_interrupt_assert <= 1'b0;
            cfg_interrupt_di     <= '0;
            irq_count            <= '0;
        end else begin
            irq_req_q   <= irq_req;
            irq_pending <= pending_nxt;
            sent        <= sent_nxt;

            if (done) begin
                cfg_interrupt        <= 1'b0;
                cfg_interrupt_assert <= 1'b0;
                cfg_interrupt_di     <= '0;
                irq_count            <= irq_count + COUNT_W'(1);
                state                <= IDLE;
            end

            case (state)
                IDLE: begin
                    if (!user_lnk_up) begin
                        intx_on <= 1'b0;
                    end else if (cfg_interrupt_msienable) begin
                        if (intx_on) begin
                            state                <= INTX_REQ;
                            cfg_interrupt        <= 1'b1;
                            cfg_interrupt_assert <= 1'b0;
                            cfg_interrupt_di     <= '0;
                        end else if (grant_vld) begin
                            state                <= MSI_REQ;
                            grant_q              <= grant;
                            cfg_interrupt        <= 1'b1;
                            cfg_interrupt_assert <= 1'b0;
                            cfg_interrupt_di     <= msi_vec;
                        end
                    end else if (level != intx_on) begin
                        state                <= INTX_REQ;
                        cfg_interrupt        <= 1'b1;
                        cfg_interrupt_assert <= level;
                        cfg_interrupt_di     <= '0;
                    end
                end
                MSI_REQ: begin
                    if (cfg_interrupt_rdy) begin
                        rr_ptr <= rr_nxt;
                    end
                end
                INTX_REQ: begin
                    if (cfg_interrupt_rdy) begin
                        intx_on <= cfg_interrupt_assert;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_s7_irq_ctrl.sv
// Directed bench for pcie_s7_irq_ctrl: MSI, round robin, legacy INTx, mode switch,
// masking, link-down and reset behaviour with hand-computed expectations.
module tb_pcie_s7_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lnk_up;
    logic [7:0]  irq_req;
    logic [7:0]  irq_mask;
    logic [7:0]  irq_clear;
    logic [7:0]  irq_pending;
    logic        cfg_int;
    logic        cfg_assert;
    logic [7:0]  cfg_di;
    logic        cfg_rdy;
    logic        msi_en;
    logic [2:0]  mm_en;
    logic [15:0] irq_count;

    int unsigned checks = 0;
    int unsigned passed = 0;

    pcie_s7_irq_ctrl #(
        .N_CHANNELS(8),
        .COUNT_W   (16)
    ) dut (
        .sys_clk                (clk),
        .sys_rst_n              (rst_n),
        .user_lnk_up            (lnk_up),
        .irq_req                (irq_req),
        .irq_mask               (irq_mask),
        .irq_clear              (irq_clear),
        .irq_pending            (irq_pending),
        .cfg_interrupt          (cfg_int),
        .cfg_interrupt_assert   (cfg_assert),
        .cfg_interrupt_di       (cfg_di),
        .cfg_interrupt_rdy      (cfg_rdy),
        .cfg_interrupt_msienable(msi_en),
        .cfg_interrupt_mmenable (mm_en),
        .irq_count              (irq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rdy_pulse();
        cfg_rdy = 1'b1;
        tick(1);
        cfg_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lnk_up = 1'b1; irq_req = '0; irq_mask = 8'hFF; irq_clear = '0;
        cfg_rdy = 1'b0; msi_en = 1'b1; mm_en = 3'd3;
        tick(3);
        checks++; if (cfg_int !== 1'b0) $display("FAIL reset_cfg_int: got %0b want 0", cfg_int); else passed++;
        checks++; if (irq_pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", irq_pending); else passed++;
        checks++; if (irq_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", irq_count); else passed++;
        checks++; if ({cfg_assert, cfg_di} !== 9'd0) $display("FAIL reset_assert_di: got %h want 000", {cfg_assert, cfg_di}); else passed++;
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_msi_single();
        msi_en = 1'b1; mm_en = 3'd3;
        irq_req = 8'h20;
        tick(1);
        checks++; if (irq_pending !== 8'h20) $display("FAIL single_pending: got %h want 20", irq_pending); else passed++;
        checks++; if (cfg_int !== 1'b0) $display("FAIL single_latency_early: got %0b want 0", cfg_int); else passed++;
        tick(1);
        checks++; if (cfg_int !== 1'b1) $display("FAIL single_req: got %0b want 1", cfg_int); else passed++;
        checks++; if (cfg_di !== 8'd5) $display("FAIL single_di: got %0d want 5", cfg_di); else passed++;
        tick(4);
        checks++; if ({cfg_int, cfg_assert, cfg_di} !== {1'b1, 1'b0, 8'd5}) $display("FAIL single_hold: got %h want 105", {cfg_int, cfg_assert, cfg_di}); else passed++;
        rdy_pulse();
        checks++; if (cfg_int !== 1'b0) $display("FAIL single_drop: got %0b want 0", cfg_int); else passed++;
        checks++; if (irq_count !== 16'd1) $display("FAIL single_count: got %0d want 1", irq_count); else passed++;
        checks++; if (irq_pending !== 8'h20) $display("FAIL single_pending_kept: got %h want 20", irq_pending); else passed++;
        tick(3);
        checks++; if (cfg_int !== 1'b0) $display("FAIL single_no_repeat: got %0b want 0", cfg_int); else passed++;
        irq_req = '0; irq_clear = 8'h20;
        tick(1);
        irq_clear = '0;
        checks++; if (irq_pending !== 8'h00) $display("FAIL single_clear: got %h want 00", irq_pending); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        msi_en = 1'b1; mm_en = 3'd1;
        irq_req = 8'hFF;
        tick(2);
        for (int n = 0; n < 8; n++) begin
            checks++; if (cfg_int !== 1'b1) $display("FAIL rr_req%0d: got %0b want 1", n, cfg_int); else passed++;
            checks++; if (cfg_di !== 8'(n % 2)) $display("FAIL rr_di%0d: got %0d want %0d", n, cfg_di, n % 2); else passed++;
            rdy_pulse();
            checks++; if (cfg_int !== 1'b0 || irq_count !== 16'(n + 1)) $display("FAIL rr_done%0d: int=%0b count=%0d want 0/%0d", n, cfg_int, irq_count, n + 1); else passed++;
            tick(1);
        end
        tick(3);
        checks++; if (cfg_int !== 1'b0) $display("FAIL rr_no_repeat: got %0b want 0", cfg_int); else passed++;
        checks++; if (irq_pending !== 8'hFF) $display("FAIL rr_pending: got %h want FF", irq_pending); else passed++;
        // re-trigger channel 3 while still pending -> one more MSI, vector 3&1 = 1
        irq_req = 8'hF7;
        tick(1);
        irq_req = 8'hFF;
        tick(2);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd1) $display("FAIL rr_retrigger: int=%0b di=%0d want 1/1", cfg_int, cfg_di); else passed++;
        rdy_pulse();
        checks++; if (irq_count !== 16'd9) $display("FAIL rr_retrigger_count: got %0d want 9", irq_count); else passed++;
        irq_req = '0; irq_clear = 8'hFF;
        tick(1);
        irq_clear = '0;
        tick(1);
    endtask

    task automatic test_legacy();
        do_reset();
        msi_en = 1'b0; mm_en = 3'd3;
        irq_req = 8'h04;
        tick(2);
        checks++; if ({cfg_int, cfg_assert, cfg_di} !== {1'b1, 1'b1, 8'd0}) $display("FAIL legacy_assert: got %h want 300", {cfg_int, cfg_assert, cfg_di}); else passed++;
        rdy_pulse();
        checks++; if (irq_count !== 16'd1) $display("FAIL legacy_count1: got %0d want 1", irq_count); else passed++;
        tick(2);
        checks++; if (cfg_int !== 1'b0) $display("FAIL legacy_steady: got %0b want 0", cfg_int); else passed++;
        irq_clear = 8'h04;
        tick(1);
        irq_clear = '0;
        tick(1);
        checks++; if ({cfg_int, cfg_assert, cfg_di} !== {1'b1, 1'b0, 8'd0}) $display("FAIL legacy_deassert: got %h want 200", {cfg_int, cfg_assert, cfg_di}); else passed++;
        rdy_pulse();
        checks++; if (irq_count !== 16'd2) $display("FAIL legacy_count2: got %0d want 2", irq_count); else passed++;
        irq_req = '0;
        tick(2);
        checks++; if (cfg_int !== 1'b0) $display("FAIL legacy_idle: got %0b want 0", cfg_int); else passed++;
    endtask

    task automatic test_mask_boundary();
        msi_en = 1'b1; mm_en = 3'd3; irq_mask = 8'h00;
        irq_req = 8'h02; irq_clear = 8'h02;
        tick(1);
        irq_clear = '0;
        checks++; if (irq_pending !== 8'h02) $display("FAIL set_clear_collision: got %h want 02", irq_pending); else passed++;
        tick(3);
        checks++; if (cfg_int !== 1'b0) $display("FAIL masked_no_req: got %0b want 0", cfg_int); else passed++;
        irq_mask = 8'h02;
        tick(1);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd1) $display("FAIL unmask_fire: int=%0b di=%0d want 1/1", cfg_int, cfg_di); else passed++;
        rdy_pulse();
        checks++; if (irq_count !== 16'd3) $display("FAIL unmask_count: got %0d want 3", irq_count); else passed++;
        irq_mask = 8'hFF; irq_req = '0; irq_clear = 8'hFF;
        tick(1);
        irq_clear = '0;
        tick(1);
    endtask

    task automatic test_mode_switch();
        do_reset();
        msi_en = 1'b0; mm_en = 3'd3;
        irq_req = 8'h09;
        tick(2);
        checks++; if (cfg_int !== 1'b1 || cfg_assert !== 1'b1) $display("FAIL mode_intx_on: int=%0b assert=%0b want 1/1", cfg_int, cfg_assert); else passed++;
        rdy_pulse();
        msi_en = 1'b1;
        tick(1);
        checks++; if ({cfg_int, cfg_assert, cfg_di} !== {1'b1, 1'b0, 8'd0}) $display("FAIL mode_deassert_first: got %h want 200", {cfg_int, cfg_assert, cfg_di}); else passed++;
        rdy_pulse();
        tick(1);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd0) $display("FAIL mode_msi0: int=%0b di=%0d want 1/0", cfg_int, cfg_di); else passed++;
        rdy_pulse();
        tick(1);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd3) $display("FAIL mode_msi3: int=%0b di=%0d want 1/3", cfg_int, cfg_di); else passed++;
        rdy_pulse();
        tick(2);
        checks++; if (cfg_int !== 1'b0 || irq_count !== 16'd4) $display("FAIL mode_end: int=%0b count=%0d want 0/4", cfg_int, irq_count); else passed++;
        irq_req = '0;
        tick(1);
    endtask

    task automatic test_link();
        do_reset();
        msi_en = 1'b1; mm_en = 3'd3; lnk_up = 1'b0;
        irq_req = 8'h10;
        tick(4);
        checks++; if (cfg_int !== 1'b0 || irq_pending !== 8'h10) $display("FAIL link_down_hold: int=%0b pend=%h want 0/10", cfg_int, irq_pending); else passed++;
        lnk_up = 1'b1;
        tick(1);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd4) $display("FAIL link_up_fire: int=%0b di=%0d want 1/4", cfg_int, cfg_di); else passed++;
        lnk_up = 1'b0; msi_en = 1'b0; mm_en = 3'd0;
        tick(3);
        checks++; if ({cfg_int, cfg_assert, cfg_di} !== {1'b1, 1'b0, 8'd4}) $display("FAIL link_drop_held: got %h want 104", {cfg_int, cfg_assert, cfg_di}); else passed++;
        rdy_pulse();
        checks++; if (cfg_int !== 1'b0 || irq_count !== 16'd1) $display("FAIL link_drop_done: int=%0b count=%0d want 0/1", cfg_int, irq_count); else passed++;
        tick(2);
        checks++; if (cfg_int !== 1'b0) $display("FAIL link_down_no_new: got %0b want 0", cfg_int); else passed++;
        lnk_up = 1'b1; msi_en = 1'b1; mm_en = 3'd3;
        tick(1);
    endtask

    task automatic test_reset_mid();
        irq_req = 8'h50;
        tick(2);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd6) $display("FAIL rst_mid_pre: int=%0b di=%0d want 1/6", cfg_int, cfg_di); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({cfg_int, cfg_assert, cfg_di, irq_pending, irq_count} !== 34'd0) $display("FAIL rst_mid_async: got %h want 0", {cfg_int, cfg_assert, cfg_di, irq_pending, irq_count}); else passed++;
        irq_req = '0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checks++; if (cfg_int !== 1'b0 || irq_count !== 16'd0) $display("FAIL rst_mid_quiet: int=%0b count=%0d want 0/0", cfg_int, irq_count); else passed++;
        cfg_rdy = 1'b1;
        tick(2);
        cfg_rdy = 1'b0;
        checks++; if (irq_count !== 16'd0) $display("FAIL rdy_idle_ignored: got %0d want 0", irq_count); else passed++;
        irq_req = 8'h80;
        tick(2);
        checks++; if (cfg_int !== 1'b1 || cfg_di !== 8'd7) $display("FAIL rst_new_edge: int=%0b di=%0d want 1/7", cfg_int, cfg_di); else passed++;
        rdy_pulse();
        checks++; if (irq_count !== 16'd1) $display("FAIL rst_new_count: got %0d want 1", irq_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_msi_single();
        test_round_robin();
        test_legacy();
        test_mask_boundary();
        test_mode_switch();
        test_link();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
